// File: rtl/fnd_scan_ctrl.sv
// Scan controller for a 4-digit multiplexed FND: converts a binary word to BCD
// with a serial double-dabble engine and time-multiplexes the digits onto the decoder.
module fnd_scan_ctrl #(
  parameter int CLK_HZ  = 100_000_000,
  parameter int SCAN_HZ = 1000,
  parameter int DATA_W  = 14,
  parameter int LZB     = 1
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_load,
  input  logic [DATA_W-1:0] i_value,
  output logic              o_busy,
  output logic              o_overflow,
  output logic [1:0]        o_digitSelect,
  output logic [3:0]        o_value,
  output logic              o_en
);

  localparam int DIV = CLK_HZ / SCAN_HZ;
  localparam int PW  = $clog2(DIV);
  localparam int CW  = $clog2(DATA_W + 1);
  localparam logic [PW-1:0]     PRE_LAST = PW'(DIV - 1);
  localparam logic [DATA_W-1:0] MAX_BIN  = DATA_W'(9999);

  typedef enum logic [1:0] {IDLE, CONV, COMMIT} state_t;

  state_t            r_state;
  logic [PW-1:0]     r_prescale;
  logic [1:0]        r_sel;
  logic [DATA_W-1:0] r_bin;
  logic [15:0]       r_bcd;
  logic [CW-1:0]     r_bitCnt;
  logic              r_ovfPend;
  logic [15:0]       r_disp;

  logic [16:0]       w_valueExt;
  logic              w_inOvf;
  logic [DATA_W-1:0] w_clampedBin;
  logic [15:0]       w_bcdAdj;
  logic              w_upperZero;

  assign w_valueExt   = 17'(i_value);
  assign w_inOvf      = (w_valueExt > 17'd9999);
  assign w_clampedBin = w_inOvf ? MAX_BIN : i_value;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_prescale <= '0;
      r_sel      <= '0;
    end else if (r_prescale == PRE_LAST) begin
      r_prescale <= '0;
      r_sel      <= r_sel + 2'd1;
    end else begin
      r_prescale <= r_prescale + PW'(1);
    end
  end

  // Add-3 correction applied to every nibble before the next shift.
  always_comb begin
    w_bcdAdj = r_bcd;
    for (int k = 0; k < 4; k++) begin
      if (r_bcd[4*k +: 4] >= 4'd5) begin
        w_bcdAdj[4*k +: 4] = r_bcd[4*k +: 4] + 4'd3;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state    <= IDLE;
      r_bin      <= '0;
      r_bcd      <= '0;
      r_bitCnt   <= '0;
      r_ovfPend  <= 1'b0;
      r_disp     <= '0;
      o_busy     <= 1'b0;
      o_overflow <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_load) begin
            r_bin     <= w_clampedBin;
            r_ovfPend <= w_inOvf;
            r_bcd     <= '0;
            r_bitCnt  <= CW'(DATA_W);
            o_busy    <= 1'b1;
            r_state   <= CONV;
          end
        end
        CONV: begin
          r_bcd    <= (w_bcdAdj << 1) | {15'd0, r_bin[DATA_W-1]};
          r_bin    <= r_bin << 1;
          r_bitCnt <= r_bitCnt - CW'(1);
          if (r_bitCnt == CW'(1)) begin
            r_state <= COMMIT;
          end
        end
        COMMIT: begin
          r_disp     <= r_bcd;
          o_overflow <= r_ovfPend;
          o_busy     <= 1'b0;
          r_state    <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // A digit is blanked only if it and every more significant digit are zero.
  always_comb begin
    w_upperZero = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if ((k >= int'(r_sel)) && (r_disp[4*k +: 4] != 4'd0)) begin
        w_upperZero = 1'b0;
      end
    end
  end

  assign o_digitSelect = r_sel;
  assign o_value       = r_disp[{r_sel, 2'b00} +: 4];
  assign o_en          = !((LZB != 0) && (r_sel != 2'd0) && w_upperZero);

endmodule

// File: tb/tb_fnd_scan_ctrl.sv
// Self-checking bench for fnd_scan_ctrl: two instances (blanking on and off)
// compared every sample against an arithmetic model of the display.
module tb_fnd_scan_ctrl;

  localparam int CLK_HZ  = 1000;
  localparam int SCAN_HZ = 250;
  localparam int DIV     = CLK_HZ / SCAN_HZ;
  localparam int DATA_W  = 14;

  logic              clk = 1'b0;
  logic              resetN;
  logic              load;
  logic [DATA_W-1:0] value;

  logic       busyA, ovfA, enA, busyB, ovfB, enB;
  logic [1:0] selA, selB;
  logic [3:0] valA, valB;

  int checks   = 0;
  int failures = 0;
  int edgeCount;
  int dispModel = 0;
  int ovfModel  = 0;
  int busyModel = 0;
  int pow10 [4] = '{1, 10, 100, 1000};

  fnd_scan_ctrl #(.CLK_HZ(CLK_HZ), .SCAN_HZ(SCAN_HZ), .DATA_W(DATA_W), .LZB(1)) dut (
    .i_clk(clk), .i_reset_n(resetN), .i_load(load), .i_value(value),
    .o_busy(busyA), .o_overflow(ovfA), .o_digitSelect(selA), .o_value(valA), .o_en(enA)
  );

  fnd_scan_ctrl #(.CLK_HZ(CLK_HZ), .SCAN_HZ(SCAN_HZ), .DATA_W(DATA_W), .LZB(0)) dutNz (
    .i_clk(clk), .i_reset_n(resetN), .i_load(load), .i_value(value),
    .o_busy(busyB), .o_overflow(ovfB), .o_digitSelect(selB), .o_value(valB), .o_en(enB)
  );

  always #5 clk = ~clk;

  // Edges seen since reset release; the expected digit select is derived from it.
  always @(posedge clk or negedge resetN) begin
    if (!resetN) edgeCount <= 0;
    else         edgeCount <= edgeCount + 1;
  end

  task automatic compare(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic checkOutput(input string tag);
    int s;
    int digit;
    s     = (edgeCount / DIV) % 4;
    digit = (dispModel / pow10[s]) % 10;
    compare({tag, ".selA"},  32'(selA),  32'(s));
    compare({tag, ".selB"},  32'(selB),  32'(s));
    compare({tag, ".valA"},  32'(valA),  32'(digit));
    compare({tag, ".valB"},  32'(valB),  32'(digit));
    compare({tag, ".enA"},   32'(enA),   32'((s == 0) || (dispModel >= pow10[s])));
    compare({tag, ".enB"},   32'(enB),   32'(1));
    compare({tag, ".busyA"}, 32'(busyA), 32'(busyModel));
    compare({tag, ".busyB"}, 32'(busyB), 32'(busyModel));
    compare({tag, ".ovfA"},  32'(ovfA),  32'(ovfModel));
    compare({tag, ".ovfB"},  32'(ovfB),  32'(ovfModel));
  endtask

  task automatic scanAll(input string tag);
    repeat (4 * DIV) begin
      @(negedge clk);
      checkOutput(tag);
    end
  endtask

  // Loads v; optionally pulses a second strobe (dropVal) dropAt cycles into the busy window.
  task automatic applyStimulus(input int v, input int dropAt, input int dropVal);
    @(negedge clk);
    load  = 1'b1;
    value = DATA_W'(v);
    for (int c = 0; c <= DATA_W; c++) begin
      @(negedge clk);
      busyModel = 1;
      checkOutput("busy");
      load  = (c == dropAt);
      value = (c == dropAt) ? DATA_W'(dropVal) : DATA_W'(v);
    end
    @(negedge clk);
    load      = 1'b0;
    dispModel = (v > 9999) ? 9999 : v;
    ovfModel  = (v > 9999) ? 1 : 0;
    busyModel = 0;
    checkOutput("commit");
  endtask

  initial begin
    resetN = 1'b0;
    load   = 1'b0;
    value  = '0;
    #12;
    checkOutput("inReset");
    #10 resetN = 1'b1;

    $display("[TB] idle scan after reset");
    scanAll("idle");

    $display("[TB] directed loads");
    applyStimulus(1234, -1, 0);  scanAll("v1234");
    applyStimulus(42, -1, 0);    scanAll("v42");
    applyStimulus(12000, -1, 0); scanAll("v12000");
    applyStimulus(7, -1, 0);     scanAll("v7");
    applyStimulus(9999, -1, 0);  scanAll("v9999");
    applyStimulus(10000, -1, 0); scanAll("v10000");
    applyStimulus(0, -1, 0);     scanAll("v0");

    $display("[TB] strobe during busy is dropped");
    applyStimulus(5678, 5, 1111);
    scanAll("v5678");

    $display("[TB] random loads");
    repeat (10) begin
      int r;
      r = int'($urandom_range(0, 16383));
      applyStimulus(r, -1, 0);
      scanAll("rand");
    end

    $display("[TB] async reset mid-conversion");
    applyStimulus(12000, -1, 0);
    repeat (3) @(negedge clk);
    load  = 1'b1;
    value = DATA_W'(4321);
    @(negedge clk);
    load = 1'b0;
    repeat (5) @(negedge clk);
    #2 resetN = 1'b0;
    #1;
    dispModel = 0;
    ovfModel  = 0;
    busyModel = 0;
    checkOutput("asyncReset");
    @(negedge clk);
    checkOutput("holdReset");
    #3 resetN = 1'b1;
    scanAll("postReset");
    applyStimulus(42, -1, 0);
    scanAll("postResetLoad");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fnd_scan_ctrl.md
Name: fnd_scan_ctrl

Overview:
Sequential controller that drives the shared 4-digit multiplexed FND decoder from a binary result word. On a load strobe it converts the binary value to 4 BCD digits with a multi-cycle double-dabble engine. It then time-multiplexes those digits onto the decoder's digit-select, value and enable inputs at a fixed per-digit refresh rate. It sits between the adder/subtractor result path and the BCD-to-FND decoder and owns all display sequencing.

Parameters:
CLK_HZ, 100_000_000, input clock frequency in Hz.
SCAN_HZ, 1000, per-digit dwell rate in Hz. DIV = CLK_HZ/SCAN_HZ, which must be ≥2.
DATA_W, 14, width of binary input (4..16).
LZB, 1, leading-zero blanking enable (1 = blank, 0 = show zeros).

Ports:
i_clk  in  1  system clock, rising edge.
i_reset_n  in  1  asynchronous active-low reset.
i_load  in  1  single-cycle strobe; capture i_value and start conversion.
i_value  in  DATA_W  unsigned binary value to display.
o_busy  out  1  conversion in progress; i_load ignored while high.
o_overflow  out  1  last committed value exceeded 9999 and was clamped.
o_digitSelect  out  2  digit being driven (0 = ones … 3 = thousands).
o_value  out  4  BCD digit for the selected position.
o_en  out  1  digit enable to decoder (0 = blank).

Behaviour:
- Reset (i_reset_n low, async):
  - Prescaler = 0, o_digitSelect = 0, all display digit regs = 0.
  - o_busy = 0, o_overflow = 0, FSM = IDLE.
  - Consequently o_value = 0 and o_en = 1 (digit 0 is never blanked).
- Reset asserted mid-conversion aborts it; the display regs return to 0.
- Prescaler:
  - Counts 0..DIV-1 and wraps.
  - A scan tick fires when the count = DIV-1.
  - On each tick, o_digitSelect advances 0→1→2→3→0 (registered).
- Display outputs:
  - o_value = display_reg[o_digitSelect], combinational from registers, no extra latency.
  - o_en = 1, except when LZB=1, sel≥1, and every display digit at positions ≥sel is 0; then o_en = 0.
- Scanning runs continuously and independently of the FSM. Display regs change only at commit, so the panel never shows partially converted data.
- FSM states: IDLE, CONV, COMMIT.
  - IDLE: on edge E0 with i_load=1, capture min(i_value, 9999) into the shift register. Record ovf = (i_value > 9999), clear the BCD accumulator, set bit counter = DATA_W, set o_busy = 1, go to CONV.
  - CONV: each edge performs one double-dabble step. First add 3 to every BCD nibble ≥5, then shift {bcd, bin} left by 1, then decrement the counter. After DATA_W steps (edge E_DATA_W), go to COMMIT.
  - COMMIT: at edge E(DATA_W+1), copy BCD to the display regs and ovf to o_overflow, set o_busy = 0, go to IDLE.
- o_busy is high for exactly DATA_W+1 cycles. A new i_load is accepted on the first cycle o_busy is low.
- i_load while o_busy=1 is dropped; there is no queueing.
- Simultaneous scan tick and commit: the select advances and the new digit values appear together on the next cycle. Both are legal.
- Values ≤ 9999 convert exactly. DATA_W < 14 can never overflow.

Test Plan:
1. Reset then release, CLK_HZ=1000, SCAN_HZ=250 (DIV=4) -> o_digitSelect steps 0,1,2,3,0 every 4 cycles. o_value=0 always. o_en=1 only at sel 0 (LZB=1).
2. Load 1234 -> o_busy high exactly 15 cycles (DATA_W=14). Afterwards sel 0..3 shows 4,3,2,1, all o_en=1, o_overflow=0.
3. Load 42 with LZB=1 -> digits 2,4 enabled. sel 2,3 give o_en=0. With LZB=0 all four are enabled and show 2,4,0,0.
4. Load 12000 -> display 9,9,9,9 and o_overflow=1. A following load of 7 -> o_overflow=0, digits 7,0,0,0.
5. Load 5678, then pulse i_load=1111 while o_busy=1 -> second strobe ignored. Final display 5678. Display holds the old value until the commit cycle.
6. Assert i_reset_n low mid-CONV and mid-scan -> all outputs return to reset values immediately (async). After release, scan resumes from sel 0 with value 0.
